apb_fsm_controller: RTL and testbench

- APB-side sequencer of the AHB-to-APB bridge; sits between the AHB slave interface and up to three APB peripherals.
- Consumes the slave interface's qualified transfer strobe, pipelined address/data, registered write flag and slave-select code.
- Drives the APB SETUP/ENABLE protocol.
- Drives hreadyout back to the AHB master to stall it while the APB side catches up.

---
 rtl/apb_fsm_controller.sv | 147 ++++++++++++++
 tb/tb_apb_fsm_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge.
// Runs SETUP/ENABLE toward up to three peripherals and stalls the AHB master.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwritereg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic [2:0]        temp_selx,
  output logic [2:0]        pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  state_t state, state_n;

  logic [2:0] sel1, sel2;

  logic [2:0]        pselx_n;
  logic              penable_n;
  logic              pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;
  logic              hreadyout_n;

  function automatic logic [2:0] decode(input logic [2:0] code);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (1'b1)
      (code == 3'd1): oh = 3'b001;
      (code == 3'd2): oh = 3'b010;
      (code == 3'd3): oh = 3'b100;
      default:        oh = 3'b000;
    endcase
    return oh;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_WENABLE, ST_RENABLE: begin
        if (valid && hwrite)  state_n = ST_WWAIT;
        else if (valid)       state_n = ST_READ;
        else                  state_n = ST_IDLE;
      end
      ST_WWAIT:    state_n = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     state_n = ST_RENABLE;
      ST_WRITE:    state_n = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   state_n = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!hwritereg)  state_n = ST_READ;
        else if (valid)  state_n = ST_WRITEP;
        else             state_n = ST_WRITE;
      end
      default:     state_n = ST_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    pselx_n     = pselx;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    hreadyout_n = hreadyout;
    case (state_n)
      ST_IDLE, ST_WWAIT: begin
        pselx_n     = 3'b000;
        penable_n   = 1'b0;
        hreadyout_n = 1'b1;
      end
      ST_READ: begin
        paddr_n     = haddr;
        pwrite_n    = 1'b0;
        pselx_n     = decode(temp_selx);
        penable_n   = 1'b0;
        hreadyout_n = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        if (state == ST_WENABLEP) begin
          paddr_n  = haddr2;
          pwdata_n = hwdata1;
          pselx_n  = decode(sel2);
        end else begin
          paddr_n  = haddr1;
          pwdata_n = hwdata;
          pselx_n  = decode(sel1);
        end
        pwrite_n    = 1'b1;
        penable_n   = 1'b0;
        hreadyout_n = (state_n == ST_WRITE);
      end
      default: begin
        penable_n   = 1'b1;
        hreadyout_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      sel1      <= 3'b000;
      sel2      <= 3'b000;
      pselx     <= 3'b000;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state     <= state_n;
      sel1      <= temp_selx;
      sel2      <= sel1;
      pselx     <= pselx_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      hreadyout <= hreadyout_n;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboard bench for apb_fsm_controller.
// Directed rows queue expected outputs per edge; a negedge monitor checks them.
module tb_apb_fsm_controller;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        valid;
  logic        hwrite;
  logic        hwritereg = 1'b0;
  logic [31:0] haddr;
  logic [31:0] haddr1 = '0;
  logic [31:0] haddr2 = '0;
  logic [31:0] hwdata;
  logic [31:0] hwdata1 = '0;
  logic [2:0]  temp_selx;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hreadyout;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .valid     (valid),
    .hwrite    (hwrite),
    .hwritereg (hwritereg),
    .haddr     (haddr),
    .haddr1    (haddr1),
    .haddr2    (haddr2),
    .hwdata    (hwdata),
    .hwdata1   (hwdata1),
    .temp_selx (temp_selx),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hreadyout (hreadyout)
  );

  always #5 hclk = ~hclk;

  // Delayed copies the AHB slave interface would supply.
  always @(posedge hclk) begin
    hwritereg <= hwrite;
    haddr1    <= haddr;
    haddr2    <= haddr1;
    hwdata1   <= hwdata;
  end

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  ps;
    logic        pe;
    logic        hr;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        pw;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge hclk) cyc++;

  always @(negedge hclk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s missed: sampled at cyc %0d, required cyc %0d",
                 e.nm, cyc, e.cyc);
      end else if (pselx !== e.ps || penable !== e.pe ||
                   hreadyout !== e.hr || paddr !== e.pa ||
                   pwdata !== e.pd || pwrite !== e.pw) begin
        errors++;
        $display("FAIL %s cyc=%0d got psel=%b pe=%b hr=%b pa=%h pd=%h pw=%b required psel=%b pe=%b hr=%b pa=%h pd=%h pw=%b",
                 e.nm, cyc, pselx, penable, hreadyout, paddr, pwdata,
                 pwrite, e.ps, e.pe, e.hr, e.pa, e.pd, e.pw);
      end
    end
  end

  // One row: inputs for the next edge plus outputs required after it.
  task automatic row(
    input string       nm,
    input logic        rst,
    input logic        v,
    input logic        hw,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [2:0]  s,
    input logic [2:0]  ps,
    input logic        pe,
    input logic        hr,
    input logic [31:0] pa,
    input logic [31:0] pd,
    input logic        pw
  );
    exp_t e;
    hreset    = rst;
    valid     = v;
    hwrite    = hw;
    haddr     = a;
    hwdata    = d;
    temp_selx = s;
    e.cyc = cyc + 1;
    e.nm  = nm;
    e.ps  = ps;
    e.pe  = pe;
    e.hr  = hr;
    e.pa  = pa;
    e.pd  = pd;
    e.pw  = pw;
    q.push_back(e);
    @(posedge hclk);
    #1;
  endtask

  initial begin
    row("rst0", 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0);
    row("rst1", 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0);

    for (int i = 0; i < 10; i++)
      row($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0,
          3'b000, 0, 1, 0, 0, 0);

    row("rd_setup", 0, 1, 0, 32'h8000_0010, 0, 3'd1,
        3'b001, 0, 0, 32'h8000_0010, 0, 0);
    row("rd_enable", 0, 0, 0, 32'h8000_0010, 0, 3'd1,
        3'b001, 1, 1, 32'h8000_0010, 0, 0);
    row("rd_idle", 0, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 32'h8000_0010, 0, 0);

    row("wr_wwait", 0, 1, 1, 32'h8400_0004, 0, 3'd2,
        3'b000, 0, 1, 32'h8000_0010, 0, 0);
    row("wr_setup", 0, 0, 0, 0, 32'hDEAD_BEEF, 0,
        3'b010, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1);
    row("wr_enable", 0, 0, 0, 0, 32'hDEAD_BEEF, 0,
        3'b010, 1, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1);
    row("wr_idle", 0, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1);

    row("b2b_wwait", 0, 1, 1, 32'h8800_0000, 0, 3'd3,
        3'b000, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1);
    row("b2b_writep", 0, 1, 1, 32'h8800_0004, 32'h1, 3'd3,
        3'b100, 0, 0, 32'h8800_0000, 32'h1, 1);
    row("b2b_wenp", 0, 0, 1, 32'h8800_0004, 32'h2, 3'd3,
        3'b100, 1, 1, 32'h8800_0000, 32'h1, 1);
    row("b2b_write2", 0, 0, 0, 0, 32'h2, 0,
        3'b100, 0, 1, 32'h8800_0004, 32'h2, 1);
    row("b2b_wen2", 0, 0, 0, 0, 0, 0,
        3'b100, 1, 1, 32'h8800_0004, 32'h2, 1);
    row("b2b_idle", 0, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 32'h8800_0004, 32'h2, 1);

    row("c0_setup", 0, 1, 0, 32'h8000_0020, 0, 3'd0,
        3'b000, 0, 0, 32'h8000_0020, 32'h2, 0);
    row("c0_enable", 0, 0, 0, 0, 0, 0,
        3'b000, 1, 1, 32'h8000_0020, 32'h2, 0);
    row("c0_idle", 0, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 32'h8000_0020, 32'h2, 0);

    row("wr_rd_wwait", 0, 1, 1, 32'h8000_0000, 0, 3'd1,
        3'b000, 0, 1, 32'h8000_0020, 32'h2, 0);
    row("wr_rd_writep", 0, 1, 0, 32'h8400_0008, 32'hCAFE_0001, 3'd2,
        3'b001, 0, 0, 32'h8000_0000, 32'hCAFE_0001, 1);
    row("wr_rd_wenp", 0, 0, 0, 32'h8400_0008, 32'hCAFE_0001, 3'd2,
        3'b001, 1, 1, 32'h8000_0000, 32'hCAFE_0001, 1);
    row("wr_rd_read", 0, 0, 0, 32'h8400_0008, 0, 3'd2,
        3'b010, 0, 0, 32'h8400_0008, 32'hCAFE_0001, 0);
    row("wr_rd_renable", 0, 0, 0, 0, 0, 0,
        3'b010, 1, 1, 32'h8400_0008, 32'hCAFE_0001, 0);
    row("wr_rd_idle", 0, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 32'h8400_0008, 32'hCAFE_0001, 0);

    row("mrst_wwait", 0, 1, 1, 32'h8400_0010, 0, 3'd2,
        3'b000, 0, 1, 32'h8400_0008, 32'hCAFE_0001, 0);
    row("mrst_setup", 0, 0, 0, 0, 32'h1234_5678, 0,
        3'b010, 0, 1, 32'h8400_0010, 32'h1234_5678, 1);
    row("mrst_wenable", 0, 0, 0, 0, 0, 0,
        3'b010, 1, 1, 32'h8400_0010, 32'h1234_5678, 1);
    row("mrst_rst0", 1, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 0, 0, 0);
    row("mrst_rst1", 1, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 0, 0, 0);
    row("mrst_after", 0, 0, 0, 0, 0, 0,
        3'b000, 0, 1, 0, 0, 0);

    repeat (3) @(posedge hclk);
    #1;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
